// File: rtl/y86_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_mem_pkg
// Description : Shared types and constants for the Y86-64 memory port
//               arbiter: arbiter state encoding and instruction/beat sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_mem_pkg;

    // Y86-64 instructions are at most 10 bytes; memory beats are 8 bytes.
    localparam int INSTR_BYTES = 10;
    localparam int INSTR_W     = INSTR_BYTES * 8;
    localparam int BEAT_BYTES  = 8;
    // Bytes of the second fetch beat that land in the instruction.
    localparam int BEAT1_BYTES = INSTR_BYTES - BEAT_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_D_ACC   = 3'd1,
        ST_F_BEAT0 = 3'd2,
        ST_F_BEAT1 = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : wait_timer
// Description : Wait-state counter for one memory beat. Counts cycles while
//               enabled, clears on request, and flags expiry on the cycle
//               the count would reach MAX_WAIT.
// Ports       : clk, rst_n (async active-low), clear, enable -> expire
// Revision    : 1.0 - initial release
// ============================================================================
module wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int                 c_CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(MAX_WAIT - 1);

    logic [c_CNT_W-1:0] r_count;

    // Expires on the MAX_WAIT-th enabled cycle so the caller can leave the
    // beat on that same edge.
    assign expire = enable & ~clear & (r_count == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || expire) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported 64-bit memory between the Y86-64
//               fetch stage (10-byte, two-beat reads) and the memory stage
//               (8-byte reads/writes). Data requests win arbitration; a fetch
//               in progress is never preempted. Each beat has a wait-state
//               timeout that ends the access with an error.
// Ports       : f_req/f_addr -> f_rdata/f_valid/f_err/f_stall   (fetch)
//               m_req/m_we/m_addr/m_wdata -> m_rdata/m_valid/m_err/m_stall
//               mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata/mem_err
// Config      : FETCH_BUF_EN - one-entry buffer of the last good fetch
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import y86_mem_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    // fetch stage
    input  logic               f_req,
    input  logic [ADDR_W-1:0]  f_addr,
    output logic [INSTR_W-1:0] f_rdata,
    output logic               f_valid,
    output logic               f_err,
    output logic               f_stall,
    // memory stage
    input  logic               m_req,
    input  logic               m_we,
    input  logic [ADDR_W-1:0]  m_addr,
    input  logic [DATA_W-1:0]  m_wdata,
    output logic [DATA_W-1:0]  m_rdata,
    output logic               m_valid,
    output logic               m_err,
    output logic               m_stall,
    // backing memory
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_err
);

    localparam logic [ADDR_W-1:0] c_BEAT_STRIDE = ADDR_W'(BEAT_BYTES);

    arb_state_t         r_state;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [ADDR_W-1:0]  r_f_addr;
    logic [INSTR_W-1:0] r_f_rdata;
    logic [DATA_W-1:0]  r_m_rdata;
    logic               r_f_valid;
    logic               r_f_err;
    logic               r_m_valid;
    logic               r_m_err;
    logic               r_acc_err;      // error seen on fetch beat0

    logic               w_timeout;
    logic               w_buf_hit;
    logic [INSTR_W-1:0] w_buf_data;

    // ------------------------------------------------------------------
    // Beat timeout: any cycle without an outstanding request or with an
    // ack restarts the count, so each beat gets its own MAX_WAIT budget.
    // ------------------------------------------------------------------
    wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (~r_mem_req | mem_ack),
        .enable (r_mem_req & ~mem_ack),
        .expire (w_timeout)
    );

`ifdef FETCH_BUF_EN
    // ------------------------------------------------------------------
    // One-entry instruction buffer. Filled only by an error-free two-beat
    // fetch; dropped by any granted write touching the buffered bytes.
    // ------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] c_INSTR_SPAN = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] c_BEAT_SPAN  = ADDR_W'(BEAT_BYTES);

    logic               r_buf_valid;
    logic [ADDR_W-1:0]  r_buf_addr;
    logic [INSTR_W-1:0] r_buf_data;
    logic               w_buf_fill;
    logic               w_wr_overlap;
    logic               w_buf_inval;
    logic [ADDR_W-1:0]  w_wr_off;       // write start relative to buffer
    logic [ADDR_W-1:0]  w_buf_off;      // buffer start relative to write

    // Modular offsets keep the overlap test correct across address wrap.
    assign w_wr_off     = m_addr - r_buf_addr;
    assign w_buf_off    = r_buf_addr - m_addr;
    assign w_wr_overlap = (w_wr_off < c_INSTR_SPAN) | (w_buf_off < c_BEAT_SPAN);
    assign w_buf_inval  = (r_state == ST_IDLE) & m_req & m_we & w_wr_overlap;
    assign w_buf_fill   = (r_state == ST_F_BEAT1) & mem_ack & ~mem_err & ~r_acc_err;

    assign w_buf_hit    = r_buf_valid & (f_addr == r_buf_addr);
    assign w_buf_data   = r_buf_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else if (w_buf_inval) begin
            r_buf_valid <= 1'b0;
        end else if (w_buf_fill) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= r_f_addr;
            r_buf_data  <= {mem_rdata[BEAT1_BYTES*8-1:0], r_f_rdata[DATA_W-1:0]};
        end
    end
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_data = '0;
`endif

    // ------------------------------------------------------------------
    // Arbiter FSM. All memory-side and response outputs are registered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_f_addr    <= '0;
            r_f_rdata   <= '0;
            r_m_rdata   <= '0;
            r_f_valid   <= 1'b0;
            r_f_err     <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_err     <= 1'b0;
            r_acc_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Memory stage holds the older instruction, so it wins.
                    if (m_req) begin
                        r_state     <= ST_D_ACC;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= m_we;
                        r_mem_addr  <= m_addr;
                        r_mem_wdata <= m_wdata;
                    end else if (f_req) begin
                        r_f_addr  <= f_addr;
                        r_acc_err <= 1'b0;
                        if (w_buf_hit) begin
                            r_state   <= ST_RESP;
                            r_f_rdata <= w_buf_data;
                            r_f_err   <= 1'b0;
                            r_f_valid <= 1'b1;
                        end else begin
                            r_state    <= ST_F_BEAT0;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= f_addr;
                        end
                    end
                end

                ST_D_ACC: begin
                    if (mem_ack) begin
                        r_m_rdata <= mem_rdata;
                        r_m_err   <= mem_err;
                        r_m_valid <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= ST_RESP;
                    end else if (w_timeout) begin
                        r_m_err   <= 1'b1;
                        r_m_valid <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end

                ST_F_BEAT0: begin
                    if (mem_ack) begin
                        r_f_rdata[DATA_W-1:0] <= mem_rdata;
                        r_acc_err             <= mem_err;
                        r_mem_addr            <= r_f_addr + c_BEAT_STRIDE;
                        r_state               <= ST_F_BEAT1;
                    end else if (w_timeout) begin
                        // Abandon the fetch; beat1 is skipped.
                        r_f_err   <= 1'b1;
                        r_f_valid <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end

                ST_F_BEAT1: begin
                    if (mem_ack) begin
                        r_f_rdata[INSTR_W-1:DATA_W] <= mem_rdata[BEAT1_BYTES*8-1:0];
                        r_f_err   <= r_acc_err | mem_err;
                        r_f_valid <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                    end else if (w_timeout) begin
                        r_f_err   <= 1'b1;
                        r_f_valid <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // One-cycle response pulse; requests here wait for IDLE.
                    r_f_valid <= 1'b0;
                    r_f_err   <= 1'b0;
                    r_m_valid <= 1'b0;
                    r_m_err   <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign f_rdata   = r_f_rdata;
    assign f_valid   = r_f_valid;
    assign f_err     = r_f_err;
    assign m_rdata   = r_m_rdata;
    assign m_valid   = r_m_valid;
    assign m_err     = r_m_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Stalls are gated by rst_n so every output reads 0 while in reset.
    assign f_stall = rst_n & f_req & ~r_f_valid;
    assign m_stall = rst_n & m_req & ~r_m_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. A simple
//               memory model returns byte(x) = x[7:0] + 8 (with a fixed
//               word at 0x100); acks and errors are steerable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req;
    logic [63:0] f_addr;
    logic [79:0] f_rdata;
    logic        f_valid, f_err, f_stall;
    logic        m_req, m_we;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic        m_valid, m_err, m_stall;
    logic        mem_req, mem_we, mem_ack, mem_err;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic        ack_en;
    logic        err_en;
    logic [63:0] err_addr;
    logic [63:0] beat_log[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_rdata   (f_rdata),
        .f_valid   (f_valid),
        .f_err     (f_err),
        .f_stall   (f_stall),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_valid   (m_valid),
        .m_err     (m_err),
        .m_stall   (m_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        if (a == 64'h100) return 64'h1122_3344_5566_7788;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = a[7:0] + 8'(i) + 8'h08;
        return w;
    endfunction

    assign mem_ack   = ack_en & mem_req;
    assign mem_err   = err_en & mem_req & (mem_addr == err_addr);
    assign mem_rdata = mem_word(mem_addr);

    // Log every completed beat address (pre-edge values are the acked ones).
    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack) beat_log.push_back(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one fetch from an idle port; lat = cycles from grant to f_valid
    // (0 if it never came), nbeats = memory beats used by this fetch.
    task automatic run_fetch(input logic [63:0] a, output int lat,
                             output logic [79:0] data, output int nbeats);
        int b0;
        b0     = beat_log.size();
        f_addr = a;
        f_req  = 1'b1;
        lat    = 0;
        data   = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (f_valid) begin
                lat  = k;
                data = f_rdata;
                break;
            end
        end
        f_req  = 1'b0;
        nbeats = beat_log.size() - b0;
        tick();
    endtask

    initial begin
        int          n_wait;
        logic        seen;
        int          lat;
        int          nb;
        logic [79:0] fd;

        rst_n = 1'b0; f_req = 1'b0; f_addr = '0;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        ack_en = 1'b1; err_en = 1'b0; err_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_f_valid", f_valid, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_f_rdata", f_rdata, 0);
        rst_n = 1'b1;
        tick();

        // ---- data read, zero-wait ----
        m_req = 1'b1; m_we = 1'b0; m_addr = 64'h100;
        #1;
        check("rd_stall_c0", m_stall, 1);
        tick();
        check("rd_mem_req_c1", mem_req, 1);
        check("rd_mem_addr_c1", mem_addr, 64'h100);
        check("rd_stall_c1", m_stall, 1);
        check("rd_valid_c1", m_valid, 0);
        tick();
        check("rd_valid_c2", m_valid, 1);
        check("rd_rdata", m_rdata, 64'h1122_3344_5566_7788);
        check("rd_err", m_err, 0);
        check("rd_stall_c2", m_stall, 0);
        check("rd_mem_req_c2", mem_req, 0);
        m_req = 1'b0;
        tick();
        check("rd_valid_c3", m_valid, 0);

        // ---- fetch 0x1F8, two beats ----
        f_req = 1'b1; f_addr = 64'h1F8;
        tick();
        check("f_beat0_addr", mem_addr, 64'h1F8);
        check("f_beat0_we", mem_we, 0);
        check("f_stall_c1", f_stall, 1);
        tick();
        check("f_beat1_addr", mem_addr, 64'h200);
        check("f_beat1_req", mem_req, 1);
        tick();
        check("f_valid_c3", f_valid, 1);
        check("f_rdata", f_rdata, 80'h0908_0706_0504_0302_0100);
        check("f_err", f_err, 0);
        check("f_stall_c3", f_stall, 0);
        f_req = 1'b0;
        tick();

        // ---- simultaneous requests: data first, then fetch ----
        beat_log.delete();
        m_req = 1'b1; m_we = 1'b1; m_addr = 64'h300; m_wdata = 64'hDEAD_BEEF_0123_4567;
        f_req = 1'b1; f_addr = 64'h3F8;
        tick();
        check("both_mem_we", mem_we, 1);
        check("both_mem_addr", mem_addr, 64'h300);
        check("both_mem_wdata", mem_wdata, 64'hDEAD_BEEF_0123_4567);
        tick();
        check("both_m_valid", m_valid, 1);
        check("both_f_valid_c2", f_valid, 0);
        check("both_f_stall_c2", f_stall, 1);
        m_req = 1'b0; m_we = 1'b0;
        tick();
        check("both_idle_req", mem_req, 0);
        tick();
        check("both_fbeat0_addr", mem_addr, 64'h3F8);
        tick();
        tick();
        check("both_f_valid", f_valid, 1);
        check("both_f_rdata", f_rdata, 80'h0908_0706_0504_0302_0100);
        f_req = 1'b0;
        tick();
        check("both_nbeats", beat_log.size(), 3);
        check("both_log0", beat_log[0], 64'h300);
        check("both_log1", beat_log[1], 64'h3F8);
        check("both_log2", beat_log[2], 64'h400);

        // ---- timeout: ack withheld ----
        ack_en = 1'b0;
        m_req = 1'b1; m_we = 1'b0; m_addr = 64'h500;
        n_wait = 0; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (m_valid) seen = 1'b1;
            else if (mem_req) n_wait++;
        end
        check("to_seen", seen, 1);
        check("to_wait_cycles", n_wait, 15);
        check("to_err", m_err, 1);
        check("to_mem_req", mem_req, 0);
        m_req = 1'b0; ack_en = 1'b1;
        tick();
        m_req = 1'b1; m_addr = 64'h100;
        tick();
        tick();
        check("post_to_valid", m_valid, 1);
        check("post_to_err", m_err, 0);
        check("post_to_rdata", m_rdata, 64'h1122_3344_5566_7788);
        m_req = 1'b0;
        tick();

        // ---- fetch error on beat1 only ----
        err_en = 1'b1; err_addr = 64'h208;
        run_fetch(64'h200, lat, fd, nb);
        check("ferr_lat", lat, 3);
        check("ferr_flag", f_err, 0);
        err_en = 1'b0;
        f_req = 1'b1; f_addr = 64'h200; err_en = 1'b1;
        tick(); tick(); tick();
        check("ferr_beat1", f_err, 1);
        f_req = 1'b0; err_en = 1'b0;
        tick();

        // ---- reset during F_BEAT1 ----
        f_req = 1'b1; f_addr = 64'h5F8;
        tick();
        tick();
        check("rst_pre_addr", mem_addr, 64'h600);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_f_valid", f_valid, 0);
        check("rst_mid_f_stall", f_stall, 0);
        check("rst_mid_f_rdata", f_rdata, 0);
        check("rst_mid_m_rdata", m_rdata, 0);
        beat_log.delete();
        #3 rst_n = 1'b1;
        tick();
        check("rst_refetch_addr", mem_addr, 64'h5F8);
        check("rst_refetch_req", mem_req, 1);
        tick();
        tick();
        check("rst_refetch_valid", f_valid, 1);
        check("rst_refetch_rdata", f_rdata, 80'h0908_0706_0504_0302_0100);
        check("rst_refetch_beats", beat_log.size(), 2);
        f_req = 1'b0;
        tick();

        // ---- repeat fetch of 0x40 ----
        run_fetch(64'h40, lat, fd, nb);
        check("buf_first_lat", lat, 3);
        check("buf_first_beats", nb, 2);
        check("buf_first_data", fd, 80'h5150_4F4E_4D4C_4B4A_4948);
`ifdef FETCH_BUF_EN
        run_fetch(64'h40, lat, fd, nb);
        check("buf_hit_lat", lat, 1);
        check("buf_hit_beats", nb, 0);
        check("buf_hit_data", fd, 80'h5150_4F4E_4D4C_4B4A_4948);
        m_req = 1'b1; m_we = 1'b1; m_addr = 64'h44; m_wdata = 64'h0;
        tick();
        tick();
        check("buf_wr_valid", m_valid, 1);
        m_req = 1'b0; m_we = 1'b0;
        tick();
        run_fetch(64'h40, lat, fd, nb);
        check("buf_inval_lat", lat, 3);
        check("buf_inval_beats", nb, 2);
`else
        run_fetch(64'h40, lat, fd, nb);
        check("nobuf_lat", lat, 3);
        check("nobuf_beats", nb, 2);
        check("nobuf_data", fd, 80'h5150_4F4E_4D4C_4B4A_4948);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported 64-bit backing memory between the fetch stage (10-byte instruction reads) and the memory stage (8-byte data reads/writes) of the pipelined Y86-64 core. It grants requests, sequences the two-beat instruction fetch, and returns data with error status. It drives `f_stall`/`m_stall` into the pipeline hazard/stall logic so that stages wait while the port is busy.

## Interface
- `ADDR_W`, 64, byte address width
- `DATA_W`, 64, memory beat width (fixed 64; other values unsupported)
- `MAX_WAIT`, 15, cycles `mem_req` may stay unacknowledged before timeout (1..255)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `f_req`  in  1  fetch request; held with `f_addr` stable until `f_valid`
- `f_addr`  in  ADDR_W  instruction byte address
- `f_rdata`  out  80  instruction bytes, little-endian; byte 0 at [7:0]
- `f_valid`  out  1  one-cycle pulse, `f_rdata`/`f_err` valid
- `f_err`  out  1  imem_error for the returned fetch
- `f_stall`  out  1  `f_req & ~f_valid`
- `m_req`, `m_we`  in  1  data request, write enable; held until `m_valid`
- `m_addr`  in  ADDR_W; `m_wdata`  in  64
- `m_rdata`  out  64; `m_valid`  out  1 pulse; `m_err`  out  1 dmem_error
- `m_stall`  out  1  `m_req & ~m_valid`
- `mem_req`, `mem_we`  out  1; `mem_addr`  out  ADDR_W; `mem_wdata`  out  64
- `mem_ack`  in  1  beat complete this cycle; `mem_rdata`  in  64; `mem_err`  in  1 (qualified by `mem_ack`)

## Operation
- FSM states: IDLE, D_ACC, F_BEAT0, F_BEAT1, RESP.
- IDLE: if `m_req` → D_ACC (data priority; memory stage is older). Else if `f_req` → F_BEAT0. Address/wdata/we are registered at grant.
- D_ACC: `mem_req=1`, `mem_addr=m_addr` reg; on `mem_ack` capture `mem_rdata`, `mem_err` → RESP.
- F_BEAT0: `mem_addr=f_addr`; on ack capture beat0 → F_BEAT1. F_BEAT1: `mem_addr=f_addr+8` (wraps mod 2^ADDR_W); on ack capture beat1 → RESP. `f_rdata = {beat1[15:0], beat0}`. `mem_we=0` for fetch.
- Fetch is never preempted: an `m_req` arriving during F_BEAT0/F_BEAT1 waits until IDLE.
- RESP: pulse `f_valid` or `m_valid` for the granted requester → IDLE. Requests seen in RESP are ignored; IDLE re-arbitrates.
- Error: `f_err`/`m_err` = OR of `mem_err` over all beats of the access, or timeout.
- Timeout: wait counter clears on each new beat; it increments each cycle `mem_req & ~mem_ack`. When the count reaches `MAX_WAIT`, the beat is abandoned, the error is set, and the FSM goes → RESP (a fetch skips beat1). `f_rdata`/`m_rdata` are then don't-care.
- Both requests are arbitrated in the same IDLE cycle: data wins; fetch stays stalled.

## Timing
- Reset (async, any state): state=IDLE; all outputs 0; `mem_req` drops immediately. Captured data regs cleared to 0.
- Data, zero-wait memory: cycle 0 IDLE grant, cycle 1 D_ACC with ack, cycle 2 `m_valid`, cycle 3 IDLE. Latency 2 cycles from grant to valid, plus wait states.
- Fetch, zero-wait memory: grant c0, beats c1/c2, `f_valid` c3.
- `mem_*` outputs are registered and stable while `mem_req=1` until ack.
- Stall outputs are combinational from `*_req` and registered `*_valid`.

## Configuration
- `FETCH_BUF_EN`: defined → one-entry instruction buffer holding the last successful (`f_err=0`) `f_addr`/`f_rdata`.
  - On a hit in IDLE with `m_req=0`: → RESP directly; `f_valid` is asserted the next cycle with no memory access.
  - Any granted data write whose 8-byte range overlaps the buffered 10 bytes invalidates the entry.
  - Reset invalidates the entry.
- Undefined: every fetch uses two memory beats.

## Structure
- Package `y86_mem_pkg`: state enum `arb_state_t`, `INSTR_BYTES=10`, `INSTR_W=80`, `BEAT_BYTES=8`.
- Sub-module `wait_timer`: clear/enable/expire counter parameterized by `MAX_WAIT`; used once for the timeout.

## Test plan
- Data read, `m_addr=0x100`, `mem_rdata=0x1122334455667788` acked first cycle → `m_valid` exactly 2 cycles after grant, `m_rdata` matches, `m_err=0`, `m_stall` high for 2 cycles.
- Fetch `f_addr=0x1F8`, beats `0x0706050403020100` / `0x...0908` → `mem_addr` 0x1F8 then 0x200, `f_rdata=0x09080706050403020100`.
- `f_req` and `m_req` in the same IDLE cycle → data served first; fetch granted the cycle after `m_valid`'s RESP and completes; no beat interleave.
- `mem_ack` withheld → after 15 wait cycles `m_valid=1`, `m_err=1`, `mem_req` deasserted; next request proceeds normally.
- `rst_n` low during F_BEAT1 → `mem_req`, `f_valid`, `f_stall` 0 immediately; after release, a fresh fetch restarts at beat0.
- `FETCH_BUF_EN`: repeat fetch of 0x40 → no `mem_req`, `f_valid` 1 cycle after grant; write to 0x44 then fetch 0x40 → two memory beats.
